// File: rtl/vga_timing_gen.sv
// Raster timing generator: walks an (h,v) position through a programmable
// frame and presents registered sync, blanking, data-enable and coordinates.
module vga_timing_gen #(
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 33,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  parameter int   CW        = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          line_start,
  output logic          frame_start,
  output logic          vblank
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_zero_timing
      $error("vga_timing_gen: porch and sync widths must all be non-zero");
    end
    if (longint'(H_TOTAL) > (longint'(1) << CW) ||
        longint'(V_TOTAL) > (longint'(1) << CW)) begin : g_cw_too_small
      $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CW-bit counters");
    end
  endgenerate

  // Boundaries narrowed to counter width; every one fits once the totals fit.
  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS_END  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS_END  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_SYNC_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SYNC_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_SYNC_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SYNC_END = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0] h;
  logic [CW-1:0] v;
  logic          h_vis;
  logic          v_vis;
  logic          h_in_sync;
  logic          v_in_sync;

  assign h_vis     = (h < H_VIS_END);
  assign v_vis     = (v < V_VIS_END);
  assign h_in_sync = (h >= H_SYNC_BEG) && (h < H_SYNC_END);
  assign v_in_sync = (v >= V_SYNC_BEG) && (v < V_SYNC_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= '0;
      v <= '0;
    end else if (en) begin
      if (h == H_LAST) begin
        h <= '0;
        if (v == V_LAST) begin
          v <= '0;
        end else begin
          v <= v + 1'b1;
        end
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  // Outputs decode the position the counters hold now, so they trail by one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      de          <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      vblank      <= 1'b0;
    end else if (en) begin
      hsync       <= h_in_sync ? HSYNC_POL : ~HSYNC_POL;
      vsync       <= v_in_sync ? VSYNC_POL : ~VSYNC_POL;
      de          <= h_vis && v_vis;
      pixel_x     <= (h_vis && v_vis) ? h : '0;
      pixel_y     <= (h_vis && v_vis) ? v : '0;
      line_start  <= (h == '0);
      frame_start <= (h == '0) && (v == '0);
      vblank      <= ~v_vis;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480, 800x600 with positive
// syncs, and a tiny 15x11 frame small enough to walk whole frames.
module tb_vga_timing_gen;

  logic clk;
  logic rst_n;
  logic en;

  logic        def_hsync, def_vsync, def_de, def_ls, def_fs, def_vblank;
  logic [10:0] def_px, def_py;
  logic        svga_hsync, svga_vsync, svga_de, svga_ls, svga_fs, svga_vblank;
  logic [10:0] svga_px, svga_py;
  logic        sml_hsync, sml_vsync, sml_de, sml_ls, sml_fs, sml_vblank;
  logic [3:0]  sml_px, sml_py;

  int num_checks;
  int num_errors;

  vga_timing_gen u_def (
    .clk(clk), .rst_n(rst_n), .en(en),
    .hsync(def_hsync), .vsync(def_vsync), .de(def_de),
    .pixel_x(def_px), .pixel_y(def_py),
    .line_start(def_ls), .frame_start(def_fs), .vblank(def_vblank)
  );

  vga_timing_gen #(
    .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
    .V_ACTIVE(600), .V_FP(1), .V_SYNC(4), .V_BP(23),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CW(11)
  ) u_svga (
    .clk(clk), .rst_n(rst_n), .en(en),
    .hsync(svga_hsync), .vsync(svga_vsync), .de(svga_de),
    .pixel_x(svga_px), .pixel_y(svga_py),
    .line_start(svga_ls), .frame_start(svga_fs), .vblank(svga_vblank)
  );

  // 15 x 11 frame: hsync h=10..12, vsync v=6..7, 165 clocks per frame.
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(3),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CW(4)
  ) u_sml (
    .clk(clk), .rst_n(rst_n), .en(en),
    .hsync(sml_hsync), .vsync(sml_vsync), .de(sml_de),
    .pixel_x(sml_px), .pixel_y(sml_py),
    .line_start(sml_ls), .frame_start(sml_fs), .vblank(sml_vblank)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic rst_val, input logic en_val);
    rst_n = rst_val;
    en    = en_val;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    num_checks++;
    if (obs !== exp) begin
      num_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  int d_de, d_hs_lo, d_hs_first, d_hs_last, d_px_max, d_ls;
  int s_hs_hi, s_hs_first, s_ls;
  int m_de, m_hs, m_vs, m_vb, m_ls, m_fs, m_px_max, m_py_max, m_fs_total;
  int k, pos, eh, ev;
  logic en_now;

  initial begin
    clk = 1'b0;
    num_checks = 0;
    num_errors = 0;
    d_de = 0; d_hs_lo = 0; d_hs_first = -1; d_hs_last = -1; d_px_max = 0; d_ls = 0;
    s_hs_hi = 0; s_hs_first = -1; s_ls = 0;
    m_de = 0; m_hs = 0; m_vs = 0; m_vb = 0; m_ls = 0; m_fs = 0;
    m_px_max = 0; m_py_max = 0; m_fs_total = 0;

    applyStimulus(1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_de",     32'(def_de), 0);
    checkOutput("rst_px",     32'(def_px), 0);
    checkOutput("rst_py",     32'(def_py), 0);
    checkOutput("rst_ls",     32'(def_ls), 0);
    checkOutput("rst_fs",     32'(def_fs), 0);
    checkOutput("rst_vblank", 32'(def_vblank), 0);
    checkOutput("rst_hsync",  32'(def_hsync), 1);
    checkOutput("rst_vsync",  32'(def_vsync), 1);
    checkOutput("rst_svga_hsync", 32'(svga_hsync), 0);
    checkOutput("rst_svga_vsync", 32'(svga_vsync), 0);

    applyStimulus(1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("idle_fs", 32'(def_fs), 0);
    checkOutput("idle_ls", 32'(def_ls), 0);
    checkOutput("idle_de", 32'(def_de), 0);

    // Free run: sample c is the output for position c since reset release.
    applyStimulus(1'b1, 1'b1);
    for (int c = 0; c < 1100; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) begin
        checkOutput("first_de", 32'(def_de), 1);
        checkOutput("first_ls", 32'(def_ls), 1);
        checkOutput("first_fs", 32'(def_fs), 1);
        checkOutput("first_px", 32'(def_px), 0);
        checkOutput("first_svga_fs", 32'(svga_fs), 1);
        checkOutput("first_sml_fs",  32'(sml_fs), 1);
        checkOutput("first_svga_vsync", 32'(svga_vsync), 0);
      end
      if (c == 1)   checkOutput("px_at_1", 32'(def_px), 1);
      if (c == 640) begin
        checkOutput("px_at_640", 32'(def_px), 0);
        checkOutput("de_at_640", 32'(def_de), 0);
      end
      if (c == 800) begin
        checkOutput("line1_ls", 32'(def_ls), 1);
        checkOutput("line1_fs", 32'(def_fs), 0);
        checkOutput("line1_py", 32'(def_py), 1);
        checkOutput("line1_de", 32'(def_de), 1);
      end
      if (c == 1056) checkOutput("svga_line1_ls", 32'(svga_ls), 1);
      if (c == 165)  checkOutput("sml_frame1_fs", 32'(sml_fs), 1);

      if (c < 800) begin
        if (def_de) d_de++;
        if (def_ls) d_ls++;
        if (int'(def_px) > d_px_max) d_px_max = int'(def_px);
        if (!def_hsync) begin
          d_hs_lo++;
          if (d_hs_first < 0) d_hs_first = c;
          d_hs_last = c;
        end
      end
      if (c < 1056) begin
        if (svga_ls) s_ls++;
        if (svga_hsync) begin
          s_hs_hi++;
          if (s_hs_first < 0) s_hs_first = c;
        end
      end
      if (c < 165) begin
        if (sml_de) m_de++;
        if (!sml_hsync) m_hs++;
        if (!sml_vsync) m_vs++;
        if (sml_vblank) m_vb++;
        if (sml_ls) m_ls++;
        if (sml_fs) m_fs++;
        if (int'(sml_px) > m_px_max) m_px_max = int'(sml_px);
        if (int'(sml_py) > m_py_max) m_py_max = int'(sml_py);
      end
      if (sml_fs) m_fs_total++;
    end

    checkOutput("line_de_count",  32'(d_de), 640);
    checkOutput("line_hs_count",  32'(d_hs_lo), 96);
    checkOutput("line_hs_first",  32'(d_hs_first), 656);
    checkOutput("line_hs_last",   32'(d_hs_last), 751);
    checkOutput("line_px_max",    32'(d_px_max), 639);
    checkOutput("line_ls_count",  32'(d_ls), 1);
    checkOutput("svga_hs_count",  32'(s_hs_hi), 128);
    checkOutput("svga_hs_first",  32'(s_hs_first), 840);
    checkOutput("svga_ls_count",  32'(s_ls), 1);
    checkOutput("sml_de_count",   32'(m_de), 40);
    checkOutput("sml_hs_count",   32'(m_hs), 33);
    checkOutput("sml_vs_count",   32'(m_vs), 30);
    checkOutput("sml_vb_count",   32'(m_vb), 90);
    checkOutput("sml_ls_count",   32'(m_ls), 11);
    checkOutput("sml_fs_count",   32'(m_fs), 1);
    checkOutput("sml_px_max",     32'(m_px_max), 7);
    checkOutput("sml_py_max",     32'(m_py_max), 4);
    checkOutput("sml_fs_total",   32'(m_fs_total), 7);

    // Last sample was position 1099: default (299,1), svga (43,1), small (4,7).
    checkOutput("pre_rst_de",     32'(def_de), 1);
    checkOutput("pre_rst_px",     32'(def_px), 299);
    checkOutput("pre_rst_py",     32'(def_py), 1);
    checkOutput("pre_rst_svga_px", 32'(svga_px), 43);
    checkOutput("pre_rst_sml_vb", 32'(sml_vblank), 1);
    #2;
    applyStimulus(1'b0, 1'b1);
    #1;
    checkOutput("async_rst_de",     32'(def_de), 0);
    checkOutput("async_rst_px",     32'(def_px), 0);
    checkOutput("async_rst_py",     32'(def_py), 0);
    checkOutput("async_rst_hsync",  32'(def_hsync), 1);
    checkOutput("async_rst_svga_px", 32'(svga_px), 0);
    checkOutput("async_rst_svga_de", 32'(svga_de), 0);
    checkOutput("async_rst_sml_vb", 32'(sml_vblank), 0);
    #2;

    // Alternate en; enabled samples must follow the free-running order exactly.
    k = -1;
    for (int i = 0; i < 340; i++) begin
      en_now = (i % 2 == 0);
      applyStimulus(1'b1, en_now);
      @(posedge clk);
      #1;
      if (en_now) k++;
      pos = k % 165;
      eh  = pos % 15;
      ev  = pos / 15;
      checkOutput("tog_de",     32'(sml_de), 32'(eh < 8 && ev < 5));
      checkOutput("tog_px",     32'(sml_px), (eh < 8 && ev < 5) ? eh : 0);
      checkOutput("tog_py",     32'(sml_py), (eh < 8 && ev < 5) ? ev : 0);
      checkOutput("tog_hsync",  32'(sml_hsync), 32'(!(eh >= 10 && eh < 13)));
      checkOutput("tog_vsync",  32'(sml_vsync), 32'(!(ev >= 6 && ev < 8)));
      checkOutput("tog_vblank", 32'(sml_vblank), 32'(ev >= 5));
      checkOutput("tog_ls",     32'(sml_ls), 32'(en_now && eh == 0));
      checkOutput("tog_fs",     32'(sml_fs), 32'(en_now && pos == 0));
    end
    checkOutput("tog_enabled_count", 32'(k), 169);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
